// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types and constants.
// Also used by the PC mux for the pc_src encodings.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  PC_SRC_RST = 2'b00;
    localparam logic [1:0]  PC_SRC_RUN = 2'b11;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

endpackage

// File: rtl/fetch_ack_timer.sv
// Cycle counter for the imem ack wait.
// expired_out is high while the count sits at LIMIT-1.
module fetch_ack_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic en_in,
    output logic expired_out
);

    localparam int unsigned W = $clog2(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            cnt <= '0;
        end else if (en_in) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired_out = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, imem handshake, branch redirect.
// Define MISALIGN_TRAP_EN to enable the misaligned-branch-target trap.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic [31:0] pc_out,
    output logic [1:0]  pc_src_out,
    output logic        misaligned_instr_out,
    output logic [31:0] trap_epc_out,
    output logic        fetch_err_out
);

    fetch_state_t state, state_nxt;

    logic [31:0] pc_reg;
    logic [31:0] tgt;
    logic [31:0] next_pc;
    logic        valid;
    logic        consume;
    logic        misalign;
    logic        timer_clr;
    logic        timer_en;
    logic        expired;
    logic        unused_ok;

    assign consume = valid & ~stall_in;

`ifdef MISALIGN_TRAP_EN
    assign tgt      = {branch_target_in[31:1], 1'b0};
    assign misalign = consume & branch_taken_in & branch_target_in[1];
`else
    assign tgt      = {branch_target_in[31:2], 2'b00};
    assign misalign = 1'b0;
`endif

    assign next_pc   = branch_taken_in ? tgt : pc_reg + 32'd4;
    assign unused_ok = ^{branch_target_in[1:0], TRAP_VEC, INSTR_NOP};

    fetch_ack_timer #(
        .LIMIT(ACK_TIMEOUT)
    ) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (timer_clr),
        .en_in      (timer_en),
        .expired_out(expired)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        imem_req_out         = 1'b0;
        pc_src_out           = PC_SRC_RUN;
        fetch_err_out        = 1'b0;
        misaligned_instr_out = 1'b0;
        timer_en             = 1'b0;
        timer_clr            = 1'b1;
        unique case (state)
            ST_RST: begin
                pc_src_out = PC_SRC_RST;
                state_nxt  = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_out = 1'b1;
                timer_en     = 1'b1;
                timer_clr    = imem_ack_in | expired;
                if (imem_ack_in) begin
                    state_nxt = ST_HOLD;
                end else if (expired) begin
                    fetch_err_out = 1'b1;
                end
            end
            ST_HOLD: begin
                if (misalign) begin
                    state_nxt = ST_TRAP;
                end else if (consume) begin
                    state_nxt = ST_FETCH;
                end
            end
`ifdef MISALIGN_TRAP_EN
            ST_TRAP: begin
                misaligned_instr_out = 1'b1;
                state_nxt            = ST_FETCH;
            end
`endif
            default: begin
                state_nxt = ST_RST;
            end
        endcase
    end

    // Ack is only honoured in FETCH, so a late ack after reset is dropped.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_reg    <= RESET_PC;
            instr_out <= '0;
            pc_out    <= '0;
            valid     <= 1'b0;
        end else begin
            if (state == ST_FETCH && imem_ack_in) begin
                instr_out <= imem_rdata_in;
                pc_out    <= pc_reg;
                valid     <= 1'b1;
            end
            if (consume) begin
                valid  <= 1'b0;
                pc_reg <= next_pc;
            end
`ifdef MISALIGN_TRAP_EN
            if (state == ST_TRAP) begin
                pc_reg <= TRAP_VEC;
            end
`endif
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic [31:0] trap_epc;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            trap_epc <= '0;
        end else if (misalign) begin
            trap_epc <= tgt;
        end
    end

    assign trap_epc_out = trap_epc;
`else
    assign trap_epc_out = '0;
`endif

    assign imem_addr_out   = pc_reg;
    assign instr_valid_out = valid;

endmodule
